psum_accum: RTL and testbench
=============================

# psum_accum

Sits directly downstream of a PE row and consumes its psum pulse stream (`data`, `valid`, `last_psum`). Psums are accumulated element-wise into an on-chip line buffer over a configured number of passes, one pass per filter row/input channel. After the final pass, the completed ofmap row is drained through a valid/ready output handshake. During the drain, the block asks the controller to hold the array.

## Interface
Parameters:
- `DATA_WIDTH`, 16, psum/ofmap word width.
- `MAX_OFMAP_WIDTH`, 64, line-buffer depth (maximum ofmap row length).
- `LOG_MOW`, `$clog2(MAX_OFMAP_WIDTH)`, localparam.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_ofmap_width`  in  LOG_MOW+1  psums per pass; legal range 1..MAX_OFMAP_WIDTH.
- `i_num_passes`  in  8  passes per ofmap row; 0 is treated as 1.
- `i_psum_data`  in  DATA_WIDTH  psum from the PE row.
- `i_psum_valid`  in  1  single-cycle pulse; no backpressure.
- `i_last_psum`  in  1  qualifies the final psum of a pass.
- `o_ofmap_data`  out  DATA_WIDTH  completed ofmap word.
- `o_ofmap_valid`  out  1  output valid.
- `i_ofmap_ready`  in  1  output ready.
- `o_busy`  out  1  high in DRAIN; the controller must stall PE rows.
- `o_row_done`  out  1  one-cycle pulse after the last word is accepted.
- `o_error`  out  1  sticky protocol-error flag.

## Operation
- The block has two states, ACC and DRAIN. Reset enters ACC with `col`=0 and `pass`=0.
- Accepting a psum in ACC (`i_psum_valid`=1):
  - In pass 0, `buf[col]` is written with `i_psum_data`.
  - In any other pass, `buf[col]` is written with `buf[col]` + `i_psum_data`. The add wraps modulo 2^DATA_WIDTH unless the saturation feature is enabled (see Configuration).
  - Both operands are two's-complement signed.
- End of pass: the psum accepted at `col` == `i_ofmap_width`-1 ends the pass and `col` returns to 0.
  - `i_last_psum` must be high on exactly that beat. If it is high on any other beat, or low on that beat, `o_error` is set and the pass still ends on the column count.
- End of row: if the pass just ended was pass number max(`i_num_passes`,1)-1, the state goes to DRAIN with `rd`=0. Otherwise `pass` increments.
- DRAIN:
  - Presents `buf[rd]`. Each handshake (`o_ofmap_valid` & `i_ofmap_ready`) advances `rd`.
  - The handshake at `rd` == `i_ofmap_width`-1 returns the state to ACC with `pass`=0 and `col`=0, and pulses `o_row_done`.
- `i_psum_valid` during DRAIN: the psum is dropped, `o_error` is set, and the buffer is unchanged.
- `o_error` is cleared only by `reset`.
- Configuration inputs are sampled continuously. They must be held stable except in ACC with `pass`=0 and `col`=0; changing them elsewhere gives undefined results. `o_error` is not required to flag this.

## Timing
- Reset values: `o_ofmap_data`=0, `o_ofmap_valid`=0, `o_busy`=0, `o_row_done`=0, `o_error`=0. `buf` contents are not reset.
- Buffer write: the read-modify-write completes in a single cycle. A psum accepted at cycle t is in `buf` at t+1, so back-to-back pulses to consecutive columns need no stall.
- ACC→DRAIN: the final psum is accepted at cycle t. At t+1, `o_busy`=1 and `o_ofmap_valid`=1, with `o_ofmap_data`=`buf[0]` including that final psum when `i_ofmap_width`=1.
- Output data and valid are registered. Data is held stable while valid is high and ready is low.
- With `i_ofmap_ready` held high, one word is emitted per cycle, so draining takes `i_ofmap_width` cycles.
- `o_row_done` is high on the cycle after the last handshake, together with `o_busy`=0 and `o_ofmap_valid`=0. A psum may be accepted in that same cycle.
- `reset` asserted mid-operation returns the block to ACC/pass 0 immediately, abandoning the partial row.

## Configuration
- Macro: `PSUM_ACCUM_SAT_EN`.
- Defined: the accumulate add saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. It is computed at DATA_WIDTH+1 bits and clamped.
- Undefined: the add wraps modulo 2^DATA_WIDTH and no extra adder bit is built.

## Test plan
- Width 4, passes 3, psums {1,2,3,4} in every pass with `last_psum` on the 4th, ready high: outputs {3,6,9,12} on consecutive cycles, then `o_row_done` pulses once and `o_error`=0.
- Width 3, passes 1, ready toggling 1,0,0,1,…: each word is held until its handshake, outputs are exact copies of the inputs, and `o_busy` drops with `o_row_done`.
- Width 2, passes 2, 0x7FFF+0x0001 in column 0:
  - With `PSUM_ACCUM_SAT_EN` defined, the output is 0x7FFF.
  - Without it, the output is 0x8000.
- Width 4, `last_psum` asserted on the 3rd psum: `o_error`=1 and sticky. The pass still ends after 4 psums.
- A psum pulse during DRAIN: `o_error`=1 and the drained values are unchanged.
- `reset` asserted in the middle of pass 2, followed by a clean 1-pass row {5,6}: outputs are exactly {5,6}.

Source files
------------

// File: rtl/psum_accum.sv
// psum_accum: accumulates PE-row psums into a line buffer over several passes, then drains the ofmap row.
// Define PSUM_ACCUM_SAT_EN to saturate the accumulate add instead of wrapping.
module psum_accum #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_OFMAP_WIDTH = 64,
  localparam int LOG_MOW = $clog2(MAX_OFMAP_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LOG_MOW:0]      i_ofmap_width,
  input  logic [7:0]            i_num_passes,
  input  logic [DATA_WIDTH-1:0] i_psum_data,
  input  logic                  i_psum_valid,
  input  logic                  i_last_psum,
  output logic [DATA_WIDTH-1:0] o_ofmap_data,
  output logic                  o_ofmap_valid,
  input  logic                  i_ofmap_ready,
  output logic                  o_busy,
  output logic                  o_row_done,
  output logic                  o_error
);
  typedef enum logic {ACC, DRAIN} state_t;
  state_t state, nstate;
  logic [DATA_WIDTH-1:0] mem [MAX_OFMAP_WIDTH];
  logic [LOG_MOW-1:0] col, rd, rd_n;
  logic [7:0] pass;
  logic fire, hs, last_col, last_rd, last_pass, row_end;
  logic [DATA_WIDTH-1:0] cur, sum, wdata;
  assign fire = i_psum_valid && state == ACC;
  assign hs = o_ofmap_valid && i_ofmap_ready;
  assign last_col = {1'b0, col} == i_ofmap_width - (LOG_MOW+1)'(1);
  assign last_rd = {1'b0, rd} == i_ofmap_width - (LOG_MOW+1)'(1);
  assign last_pass = pass == (i_num_passes == 8'd0 ? 8'd0 : i_num_passes - 8'd1);
  assign row_end = state == DRAIN && hs && last_rd;
  assign cur = mem[col];
`ifdef PSUM_ACCUM_SAT_EN
  logic [DATA_WIDTH:0] wide;
  assign wide = {cur[DATA_WIDTH-1], cur} + {i_psum_data[DATA_WIDTH-1], i_psum_data};
  assign sum = wide[DATA_WIDTH] != wide[DATA_WIDTH-1]
             ? (wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}})
             : wide[DATA_WIDTH-1:0];
`else
  assign sum = cur + i_psum_data;
`endif
  assign wdata = pass == 8'd0 ? i_psum_data : sum;
  assign rd_n = state == ACC ? '0 : (hs ? rd + LOG_MOW'(1) : rd);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ACC;
    else state <= nstate;
  always_comb begin
    nstate = state == ACC ? (fire && last_col && last_pass ? DRAIN : ACC)
                          : (hs && last_rd ? ACC : DRAIN);
  end
  always_comb begin
    o_busy = state == DRAIN;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      col <= '0;
      pass <= '0;
      rd <= '0;
      o_ofmap_data <= '0;
      o_ofmap_valid <= 1'b0;
      o_row_done <= 1'b0;
      o_error <= 1'b0;
    end else begin
      col <= fire ? (last_col ? '0 : col + LOG_MOW'(1)) : col;
      pass <= row_end ? '0 : (fire && last_col && !last_pass ? pass + 8'd1 : pass);
      rd <= rd_n;
      // forward the word being written so the first drained word includes the final psum
      o_ofmap_data <= fire && col == rd_n ? wdata : mem[rd_n];
      o_ofmap_valid <= nstate == DRAIN;
      o_row_done <= row_end;
      o_error <= o_error || (i_psum_valid && state == DRAIN) || (fire && i_last_psum != last_col);
    end
  always_ff @(posedge clk)
    if (fire) mem[col] <= wdata;
endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: scoreboard bench for psum_accum; expected rows come from a behavioural accumulator model.
module tb_psum_accum;
  logic clk = 0, reset = 1;
  logic [6:0] width = 7'd4;
  logic [7:0] passes = 8'd1;
  logic [15:0] pdata = '0;
  logic pvalid = 0, plast = 0, ready = 0;
  logic [15:0] o_data;
  logic o_valid, o_busy, o_row_done, o_error;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [15:0] q[$];
  logic [15:0] mbuf [64];
  int vals [8];

  psum_accum dut (
    .clk(clk), .reset(reset), .i_ofmap_width(width), .i_num_passes(passes),
    .i_psum_data(pdata), .i_psum_valid(pvalid), .i_last_psum(plast),
    .o_ofmap_data(o_data), .o_ofmap_valid(o_valid), .i_ofmap_ready(ready),
    .o_busy(o_busy), .o_row_done(o_row_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] madd(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef PSUM_ACCUM_SAT_EN
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  always @(negedge clk) if (!reset) begin
    if (o_row_done) begin
      done_cnt++;
      check("done_busy", o_busy, 0);
      check("done_valid", o_valid, 0);
    end
    if (o_valid) begin
      check("busy", o_busy, 1);
      if (q.size() == 0) check("spurious", 1, 0);
      else begin
        check("data", o_data, q[0]);
        if (ready) void'(q.pop_front());
      end
    end
  end

  task automatic psum(input logic [15:0] d, input logic l);
    @(posedge clk); #1;
    pvalid = 1; pdata = d; plast = l;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pvalid = 0; plast = 0;
  endtask

  task automatic send_pass(input int w, input int p, input int last_at);
    for (int c = 0; c < w; c++) begin
      mbuf[c] = p == 0 ? 16'(vals[c]) : madd(mbuf[c], 16'(vals[c]));
      psum(16'(vals[c]), c == last_at);
    end
  endtask

  task automatic push_row(input int w);
    for (int c = 0; c < w; c++) q.push_back(mbuf[c]);
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int start;
    bit got;
    start = done_cnt;
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(posedge clk); #1;
      ready = toggle ? (k % 3 == 0) : 1'b1;
      got = done_cnt != start;
    end
    check("row_done", got, 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - start, 1);
    check("drained", q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; pvalid = 0; plast = 0;
    #2;
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_row_done, 0);
    check("rst_err", o_error, 0);
    check("rst_data", o_data, 0);
    q.delete();
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    do_reset();
    // three passes of {1,2,3,4}
    width = 7'd4; passes = 8'd3;
    vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
    for (int p = 0; p < 3; p++) send_pass(4, p, 3);
    push_row(4);
    idle();
    wait_done(40, 0);
    check("err_clean", o_error, 0);
    // single pass with toggling ready
    width = 7'd3; passes = 8'd1;
    vals[0] = 10; vals[1] = -5; vals[2] = 300;
    send_pass(3, 0, 2);
    push_row(3);
    idle();
    wait_done(40, 1);
    check("err_toggle", o_error, 0);
    ready = 1;
    // overflow in column 0
    width = 7'd2; passes = 8'd2;
    vals[0] = 16'h7FFF; vals[1] = 1;
    send_pass(2, 0, 1);
    vals[0] = 1; vals[1] = 2;
    send_pass(2, 1, 1);
    push_row(2);
    idle();
    wait_done(40, 0);
    // reset in the middle of pass 2, then a clean row
    passes = 8'd3;
    vals[0] = 1; vals[1] = 1;
    send_pass(2, 0, 1);
    send_pass(2, 1, 1);
    psum(16'd9, 1'b0);
    idle();
    do_reset();
    passes = 8'd1;
    vals[0] = 5; vals[1] = 6;
    send_pass(2, 0, 1);
    push_row(2);
    idle();
    wait_done(40, 0);
    check("err_after_rst", o_error, 0);
    // last_psum on the 3rd beat of a 4-wide pass
    width = 7'd4;
    vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
    send_pass(4, 0, 2);
    push_row(4);
    idle();
    wait_done(40, 0);
    check("err_early_last", o_error, 1);
    vals[0] = 11; vals[1] = 12; vals[2] = 13; vals[3] = 14;
    send_pass(4, 0, 3);
    push_row(4);
    idle();
    wait_done(40, 0);
    check("err_sticky", o_error, 1);
    // psum pulse while draining
    do_reset();
    width = 7'd2; passes = 8'd1; ready = 0;
    vals[0] = 7; vals[1] = 8;
    send_pass(2, 0, 1);
    push_row(2);
    idle();
    psum(16'd99, 1'b0);
    idle();
    check("err_drain", o_error, 1);
    check("busy_held", o_busy, 1);
    wait_done(40, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
